// File: rtl/noc_q_pkg.sv
// Shared types and constants for the multi-VC router input queue.
package noc_q_pkg;

    localparam int FLIT_W = 16;
    typedef logic [FLIT_W-1:0] flit_t;

    localparam int ERR_PUSH_FULL = 0;
    localparam int ERR_POP_EMPTY = 1;
    localparam int ERR_MULTI_POP = 2;

    // VC id width; a single VC still needs a one-bit id port
    function automatic int vc_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/noc_fifo_bank.sv
// Single-VC flop FIFO; push to full and pop of empty are ignored internally.
module noc_fifo_bank #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              full,
    output logic              empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [CW-1:0]     count;
    logic              do_push;
    logic              do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Data array carries no reset; only pointers and count define validity
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/noc_vc_queue.sv
// Multi-VC router input queue: push demux, lowest-index pop select, registered output.
// Optional sticky error flags on err_o when NOC_Q_ERR_EN is defined.
module noc_vc_queue
    import noc_q_pkg::*;
#(
    parameter  int DATA_W = 16,
    parameter  int DEPTH  = 4,
    parameter  int NUM_VC = 2,
    localparam int VC_W   = vc_w(NUM_VC)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              valid_i,
    input  logic [VC_W-1:0]   vc_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic [NUM_VC-1:0] pop_req_i,
    output logic [DATA_W-1:0] data_o,
    output logic [VC_W-1:0]   vc_o,
    output logic              en_o,
    output logic [NUM_VC-1:0] full_o,
    output logic [NUM_VC-1:0] empty_o
`ifdef NOC_Q_ERR_EN
    ,
    output logic [2:0]        err_o
`endif
);

    logic [NUM_VC-1:0] bank_push;
    logic [NUM_VC-1:0] bank_pop;
    logic [DATA_W-1:0] bank_rdata [NUM_VC];

    logic              pop_any;
    logic [VC_W-1:0]   pop_sel;
    logic              sel_empty;
    logic [DATA_W-1:0] sel_rdata;
    logic              pop_acc;
    logic              push_full;

    logic [DATA_W-1:0] data_p1;
    logic [VC_W-1:0]   vc_p1;
    logic              vld_p1;

    // Ids outside 0..NUM_VC-1 match no bank, so such pushes vanish here
    always_comb begin
        bank_push = '0;
        push_full = 1'b0;
        for (int v = 0; v < NUM_VC; v++) begin
            if (valid_i && (vc_i == VC_W'(v))) begin
                bank_push[v] = 1'b1;
                push_full    = full_o[v];
            end
        end
    end

    always_comb begin
        pop_any   = 1'b0;
        pop_sel   = '0;
        sel_empty = 1'b1;
        sel_rdata = '0;
        bank_pop  = '0;
        for (int v = 0; v < NUM_VC; v++) begin
            if (pop_req_i[v] && !pop_any) begin
                pop_any = 1'b1;
                pop_sel = VC_W'(v);
            end
        end
        for (int v = 0; v < NUM_VC; v++) begin
            if (pop_sel == VC_W'(v)) begin
                sel_empty = empty_o[v];
                sel_rdata = bank_rdata[v];
            end
        end
        pop_acc = pop_any && !sel_empty;
        for (int v = 0; v < NUM_VC; v++) begin
            bank_pop[v] = pop_acc && (pop_sel == VC_W'(v));
        end
    end

    for (genvar g = 0; g < NUM_VC; g++) begin : g_bank
        noc_fifo_bank #(
            .DATA_W (DATA_W),
            .DEPTH  (DEPTH)
        ) u_bank (
            .clk   (clk),
            .rst   (rst),
            .push  (bank_push[g]),
            .pop   (bank_pop[g]),
            .wdata (data_i),
            .rdata (bank_rdata[g]),
            .full  (full_o[g]),
            .empty (empty_o[g])
        );
    end

    // Stage p1: output register, data holds when no pop is accepted
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1  <= 1'b0;
            data_p1 <= '0;
            vc_p1   <= '0;
        end else begin
            vld_p1 <= pop_acc;
            if (pop_acc) begin
                data_p1 <= sel_rdata;
                vc_p1   <= pop_sel;
            end
        end
    end

    assign data_o = data_p1;
    assign vc_o   = vc_p1;
    assign en_o   = vld_p1;

`ifdef NOC_Q_ERR_EN
    logic [2:0] err_p1;
    logic       multi_pop;

    assign multi_pop = (pop_req_i & (pop_req_i - NUM_VC'(1))) != '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            err_p1 <= '0;
        end else begin
            if (push_full)             err_p1[ERR_PUSH_FULL] <= 1'b1;
            if (pop_any && sel_empty)  err_p1[ERR_POP_EMPTY] <= 1'b1;
            if (multi_pop)             err_p1[ERR_MULTI_POP] <= 1'b1;
        end
    end

    assign err_o = err_p1;
`else
    logic unused_err;
    assign unused_err = push_full;
`endif

endmodule

// File: tb/tb_noc_vc_queue.sv
// Directed bench for noc_vc_queue with a queue-based reference model and per-cycle compare.
module tb_noc_vc_queue;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        valid_i = 1'b0;
    logic [0:0]  vc_i = '0;
    logic [15:0] data_i = '0;
    logic [1:0]  pop_req_i = '0;
    logic [15:0] data_o;
    logic [0:0]  vc_o;
    logic        en_o;
    logic [1:0]  full_o;
    logic [1:0]  empty_o;
`ifdef NOC_Q_ERR_EN
    logic [2:0]  err_o;
`endif

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    noc_vc_queue #(.DATA_W(16), .DEPTH(4), .NUM_VC(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .valid_i   (valid_i),
        .vc_i      (vc_i),
        .data_i    (data_i),
        .pop_req_i (pop_req_i),
        .data_o    (data_o),
        .vc_o      (vc_o),
        .en_o      (en_o),
        .full_o    (full_o),
        .empty_o   (empty_o)
`ifdef NOC_Q_ERR_EN
        ,
        .err_o     (err_o)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Reference model: one queue per VC, evaluated against pre-edge state
    logic [15:0] q0[$];
    logic [15:0] q1[$];
    logic [15:0] m_data = '0;
    logic        m_vc = 1'b0;
    logic        m_en = 1'b0;
    logic [2:0]  m_err = '0;
    logic        chk_on = 1'b0;

    always @(posedge clk) begin
        int n0, n1, sel;
        if (rst) begin
            q0.delete();
            q1.delete();
            m_data = '0;
            m_vc   = 1'b0;
            m_en   = 1'b0;
            m_err  = '0;
            chk_on = 1'b1;
        end else begin
            n0 = q0.size();
            n1 = q1.size();
            m_en = 1'b0;
            if (pop_req_i[0] && pop_req_i[1]) m_err[2] = 1'b1;
            sel = pop_req_i[0] ? 0 : (pop_req_i[1] ? 1 : -1);
            if (sel == 0) begin
                if (n0 > 0) begin m_data = q0.pop_front(); m_vc = 1'b0; m_en = 1'b1; end
                else m_err[1] = 1'b1;
            end else if (sel == 1) begin
                if (n1 > 0) begin m_data = q1.pop_front(); m_vc = 1'b1; m_en = 1'b1; end
                else m_err[1] = 1'b1;
            end
            if (valid_i) begin
                if (vc_i == 1'b0) begin
                    if (n0 == 4) m_err[0] = 1'b1; else q0.push_back(data_i);
                end else begin
                    if (n1 == 4) m_err[0] = 1'b1; else q1.push_back(data_i);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            chk("cyc_en_o", {31'b0, en_o}, {31'b0, m_en});
            chk("cyc_data_o", {16'b0, data_o}, {16'b0, m_data});
            chk("cyc_vc_o", {31'b0, vc_o}, {31'b0, m_vc});
            chk("cyc_full_o", {30'b0, full_o}, {30'b0, (q1.size() == 4), (q0.size() == 4)});
            chk("cyc_empty_o", {30'b0, empty_o}, {30'b0, (q1.size() == 0), (q0.size() == 0)});
`ifdef NOC_Q_ERR_EN
            chk("cyc_err_o", {29'b0, err_o}, {29'b0, m_err});
`endif
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic vc, input logic [15:0] d);
        valid_i = 1'b1; vc_i = vc; data_i = d;
        tick();
        valid_i = 1'b0;
    endtask

    task automatic pop(input logic [1:0] req);
        pop_req_i = req;
        tick();
        pop_req_i = 2'b00;
    endtask

    initial begin
        // 1: reset with a write strobe held high
        rst = 1'b1; valid_i = 1'b1; vc_i = 1'b0; data_i = 16'h5555;
        tick(); tick();
        rst = 1'b0; valid_i = 1'b0;
        chk("rst_en_o", {31'b0, en_o}, 32'd0);
        chk("rst_empty_o", {30'b0, empty_o}, 32'd3);
        chk("rst_full_o", {30'b0, full_o}, 32'd0);
        chk("rst_data_o", {16'b0, data_o}, 32'd0);
        pop(2'b01);
        chk("rst_nothing_stored", {31'b0, en_o}, 32'd0);

        // 2: per-VC ordering
        push(1'b0, 16'hA001);
        push(1'b0, 16'hA002);
        push(1'b1, 16'hB001);
        pop(2'b10);
        chk("ord_d0", {16'b0, data_o}, 32'h0000B001);
        chk("ord_v0", {31'b0, vc_o}, 32'd1);
        chk("ord_e0", {31'b0, en_o}, 32'd1);
        pop(2'b01);
        chk("ord_d1", {16'b0, data_o}, 32'h0000A001);
        chk("ord_v1", {31'b0, vc_o}, 32'd0);
        pop(2'b01);
        chk("ord_d2", {16'b0, data_o}, 32'h0000A002);
        tick();
        chk("ord_pulse", {31'b0, en_o}, 32'd0);
        chk("ord_hold", {16'b0, data_o}, 32'h0000A002);

        // 3: fill VC0, overflow, drain, underflow
        for (int i = 1; i <= 5; i++) begin
            push(1'b0, 16'(i));
            if (i == 3) chk("full_not_yet", {30'b0, full_o}, 32'd0);
            if (i >= 4) chk("full_set", {30'b0, full_o}, 32'd1);
        end
        for (int i = 1; i <= 4; i++) begin
            pop(2'b01);
            chk("drain_data", {16'b0, data_o}, 32'(i));
        end
        chk("drain_empty", {30'b0, empty_o}, 32'd3);
        pop(2'b01);
        chk("underflow_en", {31'b0, en_o}, 32'd0);
`ifdef NOC_Q_ERR_EN
        chk("err_full_empty", {29'b0, err_o}, 32'd3);
`endif

        // 4: steady push+pop across the pointer wrap
        push(1'b0, 16'hC000);
        push(1'b0, 16'hC001);
        for (int i = 0; i < 10; i++) begin
            valid_i = 1'b1; vc_i = 1'b0; data_i = 16'hC002 + 16'(i);
            pop_req_i = 2'b01;
            tick();
            chk("wrap_data", {16'b0, data_o}, 32'hC000 + 32'(i));
            chk("wrap_flags", {28'b0, full_o, empty_o}, 32'b0010);
        end
        valid_i = 1'b0;
        pop(2'b01);
        chk("wrap_tail0", {16'b0, data_o}, 32'h0000C00A);
        pop(2'b01);
        chk("wrap_tail1", {16'b0, data_o}, 32'h0000C00B);
        chk("wrap_empty", {30'b0, empty_o}, 32'd3);

        // 5: multi-hot pop request
        push(1'b0, 16'hD000);
        push(1'b1, 16'hE000);
        pop(2'b11);
        chk("multi_data", {16'b0, data_o}, 32'h0000D000);
        chk("multi_vc", {31'b0, vc_o}, 32'd0);
        chk("multi_vc1_kept", {30'b0, empty_o}, 32'd1);
        pop(2'b10);
        chk("multi_vc1_head", {16'b0, data_o}, 32'h0000E000);
        chk("multi_vc1_vc", {31'b0, vc_o}, 32'd1);
`ifdef NOC_Q_ERR_EN
        chk("err_all", {29'b0, err_o}, 32'd7);
`endif

        // 6: reset colliding with a pop
        push(1'b1, 16'hF001);
        push(1'b1, 16'hF002);
        push(1'b1, 16'hF003);
        rst = 1'b1; pop_req_i = 2'b10;
        tick();
        rst = 1'b0; pop_req_i = 2'b00;
        chk("midrst_en", {31'b0, en_o}, 32'd0);
        chk("midrst_empty", {30'b0, empty_o}, 32'd3);
        pop(2'b10);
        chk("midrst_discard", {31'b0, en_o}, 32'd0);
`ifdef NOC_Q_ERR_EN
        chk("midrst_err", {29'b0, err_o}, 32'd2);
`endif

        tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
